ping_scheduler: RTL
===================

Name: ping_scheduler

Overview:
Round-robin sequencer that shares one ultrasonic ping engine among NUM_SENSORS sensors, firing one at a time with a guard gap so echoes never overlap. It issues start and select to the engine, waits for the round-trip time or a timeout, and converts the time to millimetres. It stores one distance per sensor for the vehicle control logic. Clock is 1 MHz, so 1 cycle = 1 µs.

Parameters:
NUM_SENSORS, 4, number of sensors sharing the engine (2..8)
SEL_W, 2, width of sensor index; must satisfy 2**SEL_W >= NUM_SENSORS
GAP_CYCLES, 1000, idle cycles after each ping before the next start (echo decay guard)
TIMEOUT_CYCLES, 6000, maximum cycles to wait for ping_done after start

Ports:
clk  input  1  system clock, 1 MHz
reset  input  1  synchronous, active-high reset
enable  input  1  1 = scheduling runs; 0 = finish current ping, then park in IDLE
sensor_mask  input  NUM_SENSORS  bit i = 1 includes sensor i in rotation; sampled in SELECT only
ping_start  output  1  one-cycle pulse to the engine
ping_sel  output  SEL_W  sensor index routed to the engine; held stable from START to end of WAIT
ping_done  input  1  engine pulse: echo measured, ping_time valid this cycle
ping_fail  input  1  engine pulse: no echo (engine-side timeout)
ping_time  input  16  round-trip time in µs, valid with ping_done
dist_flat  output  16*NUM_SENSORS  distance in mm; sensor i occupies bits [16i+15:16i]
dist_valid  output  NUM_SENSORS  bit i = 1 means dist_flat slot i holds a good measurement
update  output  1  one-cycle pulse when any slot is written, whether valid or invalid
update_sel  output  SEL_W  slot written on the update pulse
cycle_done  output  1  one-cycle pulse when the rotation wraps past the highest enabled index

Behaviour:
- Reset values: ping_start=0, ping_sel=0, dist_flat=0, dist_valid=0, update=0, update_sel=0, cycle_done=0. The state machine enters IDLE and the current index is 0 with the "none fired yet" flag set.
- States:
  - IDLE: leave for SELECT when enable=1 and sensor_mask != 0.
  - SELECT (1 cycle): pick the next enabled index strictly after the current one, wrapping modulo NUM_SENSORS. The first pick after reset or after IDLE searches from index 0 inclusive. If the mask is now 0, return to IDLE.
  - START (1 cycle): ping_start=1, ping_sel=chosen index, clear the wait counter, go to WAIT.
  - WAIT: count cycles. On ping_done, write the slot and go to GAP. On ping_fail or counter==TIMEOUT_CYCLES-1 without done, mark the slot invalid and go to GAP.
  - GAP: count GAP_CYCLES cycles. Then go to SELECT if enable=1, else to IDLE.
- Simultaneous events: ping_done and ping_fail in the same cycle means done wins. ping_done and timeout in the same cycle means done wins. ping_done or ping_fail outside WAIT are ignored.
- Start-to-start period for one sensor is at least 2 + wait + GAP_CYCLES cycles. Only one ping is outstanding at any time.
- Distance arithmetic: mm = (ping_time * 11) >> 6, a 20-bit product truncated to 16 bits (≈0.1719 mm/µs, half of 343 m/s round trip). The maximum result 11263 always fits, so no saturation is needed.
- Write on done: dist_flat slot = mm, dist_valid bit = 1, update=1, update_sel=index. All of these land on the cycle after ping_done.
- Write on fail or timeout: the slot's distance is unchanged, dist_valid bit = 0, update=1.
- Masked-off sensors keep their last slot contents and valid bits.
- cycle_done pulses in SELECT when the chosen index is less than or equal to the previous index, i.e. the rotation wrapped. It never pulses on the first pick after reset or IDLE.
- enable dropping mid-WAIT or mid-GAP does not abort the ping; parking happens only at the end of GAP.
- A mask change takes effect only at the next SELECT.
- reset at any cycle forces reset values on the next clock edge, including mid-WAIT. Any engine response after reset is ignored, because the FSM is no longer in WAIT.

Test Plan:
- Reset, enable=1, mask=4'b1111, engine returns done with ping_time=5800 after 100 cycles per ping -> starts on sel 0,1,2,3 in order; each slot = 996 mm; dist_valid=4'b1111; start-to-start spacing = 1102 cycles; cycle_done on the next SELECT of sel 0.
- mask=4'b1010 -> starts alternate on sel 1,3,1,3; slots 0 and 2 stay 0 and invalid; cycle_done fires each time sel 1 is re-picked.
- Engine never responds, TIMEOUT_CYCLES=6000 -> leaves WAIT exactly 6000 cycles after START; update pulses with dist_valid bit cleared and the previous distance kept.
- ping_done and ping_fail in the same cycle with ping_time=64 -> slot = 11 mm, valid=1.
- Drop enable during WAIT of sel 2 -> sel 2 completes and its slot is written; after GAP the FSM enters IDLE with no further ping_start. Re-enabling starts the search from 0, so sel 0 fires first.
- Assert reset mid-WAIT, then pulse ping_done 3 cycles later -> all outputs are at reset values; no update pulse; dist_flat=0.

Source files
------------

// File: rtl/ping_scheduler.sv
// Round-robin sequencer sharing one ultrasonic ping engine across NUM_SENSORS sensors.
// Fires one sensor at a time, waits for echo or timeout, converts to mm, then holds a guard gap.
module ping_scheduler #(
  parameter int NUM_SENSORS    = 4,
  parameter int SEL_W          = 2,
  parameter int GAP_CYCLES     = 1000,
  parameter int TIMEOUT_CYCLES = 6000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUM_SENSORS-1:0]     sensor_mask,
  output logic                       ping_start,
  output logic [SEL_W-1:0]           ping_sel,
  input  logic                       ping_done,
  input  logic                       ping_fail,
  input  logic [15:0]                ping_time,
  output logic [16*NUM_SENSORS-1:0]  dist_flat,
  output logic [NUM_SENSORS-1:0]     dist_valid,
  output logic                       update,
  output logic [SEL_W-1:0]           update_sel,
  output logic                       cycle_done
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, SELECT, START, WAIT, GAP} state_t;

  state_t           state;
  logic [SEL_W-1:0] cur;
  logic             first;
  logic [CW-1:0]    cnt;

  logic [SEL_W:0]   base;
  logic [SEL_W-1:0] pick;
  logic             found;
  logic             wrap;
  logic [19:0]      prod;
  logic [15:0]      mm;

  assign ping_sel = cur;

  // Two passes give "next set bit at or after base, else lowest set bit" without a modulo.
  always_comb begin
    base  = first ? '0 : ({1'b0, cur} + 1'b1);
    pick  = '0;
    found = 1'b0;
    for (int unsigned j = 0; j < NUM_SENSORS; j++) begin
      if (!found && sensor_mask[j] && ((SEL_W+1)'(j) >= base)) begin
        found = 1'b1;
        pick  = SEL_W'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_SENSORS; j++) begin
      if (!found && sensor_mask[j]) begin
        found = 1'b1;
        pick  = SEL_W'(j);
      end
    end
    wrap = !first && (pick <= cur);
  end

  // mm = time_us * 11 / 64; the 14-bit quotient always fits in 16 bits.
  assign prod = 20'(ping_time) * 20'd11;
  assign mm   = {2'b00, prod[19:6]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cur        <= '0;
      first      <= 1'b1;
      cnt        <= '0;
      ping_start <= 1'b0;
      dist_flat  <= '0;
      dist_valid <= '0;
      update     <= 1'b0;
      update_sel <= '0;
      cycle_done <= 1'b0;
    end else begin
      ping_start <= 1'b0;
      update     <= 1'b0;
      cycle_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && (sensor_mask != '0)) state <= SELECT;
        end
        SELECT: begin
          if (found) begin
            cur        <= pick;
            first      <= 1'b0;
            cycle_done <= wrap;
            ping_start <= 1'b1;
            state      <= START;
          end else begin
            first <= 1'b1;
            state <= IDLE;
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (ping_done) begin
            for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
              if (SEL_W'(i) == cur) begin
                dist_flat[16*i +: 16] <= mm;
                dist_valid[i]         <= 1'b1;
              end
            end
            update     <= 1'b1;
            update_sel <= cur;
            cnt        <= '0;
            state      <= GAP;
          end else if (ping_fail || (cnt == CW'(TIMEOUT_CYCLES - 1))) begin
            for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
              if (SEL_W'(i) == cur) dist_valid[i] <= 1'b0;
            end
            update     <= 1'b1;
            update_sel <= cur;
            cnt        <= '0;
            state      <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == CW'(GAP_CYCLES - 1)) begin
            cnt   <= '0;
            first <= !enable;
            state <= enable ? SELECT : IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
